// File: rtl/register_chain_pkg.sv
// Shared types and width helpers for the serial register-chain controller.
package register_chain_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        SETTLE = 2'd2,
        UPDATE = 2'd3
    } chain_state_e;

    // Bits needed to hold every value 0..max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/chain_shift_timer.sv
// Shift-window divider and bit counter: emits a registered step strobe in the
// last cycle of each SHIFT_DIV window and flags the final (CHAIN_LEN-th) step.
module chain_shift_timer
    import register_chain_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int SHIFT_DIV = 1,
    parameter int DIV_W     = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic run_i,
    output logic step_o,
    output logic last_o
);

    localparam int               BIT_W      = cnt_width(CHAIN_LEN);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SHIFT_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(CHAIN_LEN - 1);
    localparam logic             FIRST_STEP = (SHIFT_DIV == 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             step_q, step_d;

    assign step_o = step_q;
    assign last_o = step_q && (bit_q == BIT_LAST);

    // div_q is the position inside the current window; step_d looks one cycle ahead.
    always_comb begin
        div_d  = div_q;
        bit_d  = bit_q;
        step_d = 1'b0;
        if (start_i) begin
            div_d  = '0;
            bit_d  = '0;
            step_d = FIRST_STEP;
        end else if (run_i) begin
            if (step_q) begin
                div_d  = '0;
                bit_d  = bit_q + BIT_W'(1);
                step_d = FIRST_STEP && !last_o;
            end else begin
                div_d  = div_q + DIV_W'(1);
                step_d = (div_d == DIV_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            bit_q  <= '0;
            step_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bit_q  <= bit_d;
            step_q <= step_d;
        end
    end

endmodule

// File: rtl/register_chain_controller.sv
// Loads a word MSB-first into a serial register chain, pulses update, and
// returns the previous chain contents captured from the chain tail.
module register_chain_controller
    import register_chain_pkg::*;
#(
    parameter int CHAIN_LEN     = 32,
    parameter int SHIFT_DIV     = 1,
    parameter int UPDATE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_valid,
    input  logic [CHAIN_LEN-1:0] load_data,
    output logic                 load_ready,
    output logic                 chain_data,
    output logic                 chain_enable,
    output logic                 chain_update,
    input  logic                 chain_ret,
    output logic                 busy,
    output logic [CHAIN_LEN-1:0] rdata,
    output logic                 rdata_valid,
    output chain_state_e         state_dbg
);

    // Handshake: a word transfers in a cycle where load_valid && load_ready;
    // load_ready is high only in IDLE outside reset, and nothing is queued.

    localparam int               CNT_W    = cnt_width(max2(SHIFT_DIV, UPDATE_CYCLES));
    localparam logic [CNT_W-1:0] UPD_LAST = CNT_W'(UPDATE_CYCLES - 1);

    chain_state_e         state_q, state_d;
    logic [CHAIN_LEN-1:0] sreg_q, sreg_d;
    logic [CHAIN_LEN-1:0] rsh_q, rsh_d;
    logic [CHAIN_LEN-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]     upd_q, upd_d;
    logic                 chain_data_q, chain_data_d;
    logic                 chain_update_q, chain_update_d;
    logic                 busy_q, busy_d;
    logic                 rdata_valid_q, rdata_valid_d;
    logic                 accept, step, last;

    assign load_ready   = (state_q == IDLE) && !reset;
    assign accept       = load_valid && load_ready;
    assign chain_data   = chain_data_q;
    assign chain_enable = step;
    assign chain_update = chain_update_q;
    assign busy         = busy_q;
    assign rdata        = rdata_q;
    assign rdata_valid  = rdata_valid_q;
    assign state_dbg    = state_q;

    chain_shift_timer #(
        .CHAIN_LEN (CHAIN_LEN),
        .SHIFT_DIV (SHIFT_DIV),
        .DIV_W     (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start_i (accept),
        .run_i   (state_q == SHIFT),
        .step_o  (step),
        .last_o  (last)
    );

    always_comb begin
        state_d        = state_q;
        sreg_d         = sreg_q;
        rsh_d          = rsh_q;
        rdata_d        = rdata_q;
        upd_d          = upd_q;
        chain_update_d = chain_update_q;
        busy_d         = busy_q;
        rdata_valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = load_data;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The chain and the tail capture both move on the enabled edge.
                if (step) begin
                    sreg_d = {sreg_q[CHAIN_LEN-2:0], 1'b0};
                    rsh_d  = {rsh_q[CHAIN_LEN-2:0], chain_ret};
                    if (last) begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                upd_d          = '0;
                chain_update_d = 1'b1;
                state_d        = UPDATE;
            end
            UPDATE: begin
                if (upd_q == UPD_LAST) begin
                    chain_update_d = 1'b0;
                    busy_d         = 1'b0;
                    rdata_d        = rsh_q;
                    rdata_valid_d  = 1'b1;
                    state_d        = IDLE;
                end else begin
                    upd_d = upd_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        chain_data_d = sreg_d[CHAIN_LEN-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            sreg_q         <= '0;
            rsh_q          <= '0;
            rdata_q        <= '0;
            upd_q          <= '0;
            chain_data_q   <= 1'b0;
            chain_update_q <= 1'b0;
            busy_q         <= 1'b0;
            rdata_valid_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            sreg_q         <= sreg_d;
            rsh_q          <= rsh_d;
            rdata_q        <= rdata_d;
            upd_q          <= upd_d;
            chain_data_q   <= chain_data_d;
            chain_update_q <= chain_update_d;
            busy_q         <= busy_d;
            rdata_valid_q  <= rdata_valid_d;
        end
    end

endmodule
